// File: rtl/tank_hit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tank_hit_tracker
// Description : Hit consumer for the two-player tank game. Tracks per-tank
//               lives and post-hit invulnerability, and runs the round FSM
//               (PLAY / OVER1 / OVER2 / DRAW) that drives the game-over flags.
//               A restart keycode starts a new round once the game-over
//               screen has been held long enough.
// Ports       : frame_clk          - frame-rate clock, posedge active
//               Reset              - asynchronous active-high reset
//               shot_hit           - player-1 bullet struck tank 2
//               shot_hit2          - player-2 bullet struck tank 1
//               keycode[31:0]      - four packed USB keycodes
//               lives1/lives2      - lives remaining per tank
//               hit_flash1/2       - tank invulnerable (sprite blink enable)
//               game_over_display  - tank 1 destroyed (player 2 wins)
//               game_over_display2 - tank 2 destroyed (player 1 wins)
// Revision    : 1.0 - initial release
// ============================================================================
module tank_hit_tracker #(
  parameter int         LIVES            = 3,
  parameter int         COOLDOWN_FRAMES  = 30,
  parameter int         OVER_HOLD_FRAMES = 120,
  parameter logic [7:0] RESTART_KEY      = 8'h2C
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        shot_hit,
  input  logic        shot_hit2,
  input  logic [31:0] keycode,
  output logic [3:0]  lives1,
  output logic [3:0]  lives2,
  output logic        hit_flash1,
  output logic        hit_flash2,
  output logic        game_over_display,
  output logic        game_over_display2
);

  localparam logic [3:0] c_lives    = 4'(LIVES);
  localparam logic [7:0] c_cooldown = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] c_hold     = 8'(OVER_HOLD_FRAMES);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_OVER1 = 2'd1,
    ST_OVER2 = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_shot_q;
  logic       r_shot2_q;
  logic [3:0] r_lives1;
  logic [3:0] r_lives2;
  logic [7:0] r_cool1;
  logic [7:0] r_cool2;
  logic [7:0] r_hold;
  logic       r_flash1;
  logic       r_flash2;
  logic       r_go1;
  logic       r_go2;

  // shot_hit strikes tank 2, shot_hit2 strikes tank 1.
  logic       w_edge2;
  logic       w_edge1;
  logic       w_take1;
  logic       w_take2;
  logic       w_dead1;
  logic       w_dead2;
  logic [7:0] w_cool1_nxt;
  logic [7:0] w_cool2_nxt;
  logic       w_restart;

  assign w_edge2 = shot_hit  & ~r_shot_q;
  assign w_edge1 = shot_hit2 & ~r_shot2_q;

  // A hit is only taken while playing, outside invulnerability and while the
  // tank still has lives; the lives check keeps the counter from wrapping.
  assign w_take1 = (r_state == ST_PLAY) && w_edge1 && (r_cool1 == 8'd0) && (r_lives1 != 4'd0);
  assign w_take2 = (r_state == ST_PLAY) && w_edge2 && (r_cool2 == 8'd0) && (r_lives2 != 4'd0);

  // The taken hit removes the last life.
  assign w_dead1 = w_take1 && (r_lives1 == 4'd1);
  assign w_dead2 = w_take2 && (r_lives2 == 4'd1);

  assign w_cool1_nxt = w_take1 ? c_cooldown :
                       (r_cool1 != 8'd0) ? r_cool1 - 8'd1 : 8'd0;
  assign w_cool2_nxt = w_take2 ? c_cooldown :
                       (r_cool2 != 8'd0) ? r_cool2 - 8'd1 : 8'd0;

  assign w_restart = (keycode[7:0]   == RESTART_KEY) ||
                     (keycode[15:8]  == RESTART_KEY) ||
                     (keycode[23:16] == RESTART_KEY) ||
                     (keycode[31:24] == RESTART_KEY);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_PLAY;
      r_shot_q  <= 1'b0;
      r_shot2_q <= 1'b0;
      r_lives1  <= c_lives;
      r_lives2  <= c_lives;
      r_cool1   <= 8'd0;
      r_cool2   <= 8'd0;
      r_hold    <= 8'd0;
      r_flash1  <= 1'b0;
      r_flash2  <= 1'b0;
      r_go1     <= 1'b0;
      r_go2     <= 1'b0;
    end else begin
      // Edge detectors track the inputs in every state so that a hit held
      // across a restart is not seen as a fresh edge.
      r_shot_q  <= shot_hit;
      r_shot2_q <= shot_hit2;

      case (r_state)
        ST_PLAY: begin
          if (w_take1) r_lives1 <= r_lives1 - 4'd1;
          if (w_take2) r_lives2 <= r_lives2 - 4'd1;

          if (w_dead1 || w_dead2) begin
            // Round ends: invulnerability no longer matters.
            r_state  <= (w_dead1 && w_dead2) ? ST_DRAW :
                        w_dead1 ? ST_OVER1 : ST_OVER2;
            r_go1    <= w_dead1;
            r_go2    <= w_dead2;
            r_hold   <= c_hold;
            r_cool1  <= 8'd0;
            r_cool2  <= 8'd0;
            r_flash1 <= 1'b0;
            r_flash2 <= 1'b0;
          end else begin
            r_cool1  <= w_cool1_nxt;
            r_cool2  <= w_cool2_nxt;
            r_flash1 <= (w_cool1_nxt != 8'd0);
            r_flash2 <= (w_cool2_nxt != 8'd0);
          end
        end

        default: begin
          if (r_hold != 8'd0) begin
            r_hold <= r_hold - 8'd1;
          end else if (w_restart) begin
            r_state  <= ST_PLAY;
            r_lives1 <= c_lives;
            r_lives2 <= c_lives;
            r_go1    <= 1'b0;
            r_go2    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign lives1             = r_lives1;
  assign lives2             = r_lives2;
  assign hit_flash1         = r_flash1;
  assign hit_flash2         = r_flash2;
  assign game_over_display  = r_go1;
  assign game_over_display2 = r_go2;

endmodule
`default_nettype wire

// File: tb/tb_tank_hit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tank_hit_tracker
// Description : Self-checking bench for tank_hit_tracker. A table of
//               {inputs, hold cycles, expected outputs} records is applied in
//               order, followed by hand-written asynchronous reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_hit_tracker;

  logic        frame_clk;
  logic        Reset;
  logic        shot_hit;
  logic        shot_hit2;
  logic [31:0] keycode;
  logic [3:0]  lives1;
  logic [3:0]  lives2;
  logic        hit_flash1;
  logic        hit_flash2;
  logic        game_over_display;
  logic        game_over_display2;

  int r_errors;
  int r_checks;

  tank_hit_tracker dut (
    .frame_clk          (frame_clk),
    .Reset              (Reset),
    .shot_hit           (shot_hit),
    .shot_hit2          (shot_hit2),
    .keycode            (keycode),
    .lives1             (lives1),
    .lives2             (lives2),
    .hit_flash1         (hit_flash1),
    .hit_flash2         (hit_flash2),
    .game_over_display  (game_over_display),
    .game_over_display2 (game_over_display2)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic        sh;
    logic        sh2;
    logic [31:0] key;
    int          cyc;
    logic [3:0]  l1;
    logic [3:0]  l2;
    logic        f1;
    logic        f2;
    logic        g1;
    logic        g2;
  } vec_t;

  localparam int c_nvec = 27;
  vec_t vecs [c_nvec];

  task automatic check(input string name, input int act, input int exp);
    r_checks++;
    if (act != exp) begin
      r_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] l1, input logic [3:0] l2,
                           input logic f1, input logic f2, input logic g1, input logic g2);
    check({tag, ".lives1"}, int'(lives1), int'(l1));
    check({tag, ".lives2"}, int'(lives2), int'(l2));
    check({tag, ".flash1"}, int'(hit_flash1), int'(f1));
    check({tag, ".flash2"}, int'(hit_flash2), int'(f2));
    check({tag, ".over1"},  int'(game_over_display), int'(g1));
    check({tag, ".over2"},  int'(game_over_display2), int'(g2));
  endtask

  function automatic vec_t mk(input logic sh, input logic sh2, input logic [31:0] key,
                              input int cyc, input logic [3:0] l1, input logic [3:0] l2,
                              input logic f1, input logic f2, input logic g1, input logic g2);
    vec_t v;
    v.sh = sh; v.sh2 = sh2; v.key = key; v.cyc = cyc;
    v.l1 = l1; v.l2 = l2; v.f1 = f1; v.f2 = f2; v.g1 = g1; v.g2 = g2;
    return v;
  endfunction

  initial begin
    r_errors  = 0;
    r_checks  = 0;
    Reset     = 1'b1;
    shot_hit  = 1'b0;
    shot_hit2 = 1'b0;
    keycode   = 32'h0;

    //            sh sh2 key           cyc l1 l2 f1 f2 g1 g2
    // Single hit on tank 2; flash lasts exactly 30 frames; repeat hit dropped.
    vecs[0]  = mk(0, 0, 32'h0,         1,  3, 3, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 32'h0,         1,  3, 2, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,         9,  3, 2, 0, 1, 0, 0);
    vecs[3]  = mk(1, 0, 32'h0,         1,  3, 2, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,         19, 3, 2, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,         1,  3, 2, 0, 0, 0, 0);
    // Held-high input counts once.
    vecs[6]  = mk(1, 0, 32'h0,         1,  3, 1, 0, 1, 0, 0);
    vecs[7]  = mk(1, 0, 32'h0,         49, 3, 1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 32'h0,         1,  3, 1, 0, 0, 0, 0);
    // Three spaced hits on tank 1 end the round.
    vecs[9]  = mk(0, 1, 32'h0,         1,  2, 1, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 32'h0,         31, 2, 1, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 32'h0,         1,  1, 1, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 32'h0,         31, 1, 1, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 32'h0,         1,  0, 1, 0, 0, 1, 0);
    // Hits ignored in OVER1; restart ignored while hold counter runs.
    vecs[14] = mk(1, 0, 32'h0,         1,  0, 1, 0, 0, 1, 0);
    vecs[15] = mk(0, 0, 32'h0,         58, 0, 1, 0, 0, 1, 0);
    vecs[16] = mk(0, 0, 32'h0000002C,  1,  0, 1, 0, 0, 1, 0);
    vecs[17] = mk(0, 0, 32'h0,         59, 0, 1, 0, 0, 1, 0);
    vecs[18] = mk(0, 0, 32'h2C000000,  1,  0, 1, 0, 0, 1, 0);
    vecs[19] = mk(0, 0, 32'h002C0000,  1,  3, 3, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 32'h0,         1,  3, 3, 0, 0, 0, 0);
    // Simultaneous hits down to a draw.
    vecs[21] = mk(1, 1, 32'h0,         1,  2, 2, 1, 1, 0, 0);
    vecs[22] = mk(0, 0, 32'h0,         31, 2, 2, 0, 0, 0, 0);
    vecs[23] = mk(1, 1, 32'h0,         1,  1, 1, 1, 1, 0, 0);
    vecs[24] = mk(0, 0, 32'h0,         31, 1, 1, 0, 0, 0, 0);
    vecs[25] = mk(1, 1, 32'h0,         1,  0, 0, 0, 0, 1, 1);
    vecs[26] = mk(0, 0, 32'h00002C00,  1,  0, 0, 0, 0, 1, 1);

    // Reset state.
    repeat (3) @(posedge frame_clk);
    #1;
    check_all("reset", 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge frame_clk);
    Reset = 1'b0;
    @(posedge frame_clk);
    #1;
    check_all("post_reset", 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < c_nvec; i++) begin
      shot_hit  = vecs[i].sh;
      shot_hit2 = vecs[i].sh2;
      keycode   = vecs[i].key;
      repeat (vecs[i].cyc) @(posedge frame_clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].l1, vecs[i].l2,
                vecs[i].f1, vecs[i].f2, vecs[i].g1, vecs[i].g2);
    end

    // Asynchronous reset mid-hold (still in DRAW): no clock edge needed.
    shot_hit  = 1'b0;
    shot_hit2 = 1'b0;
    keycode   = 32'h0;
    #1;
    Reset = 1'b1;
    #1;
    check_all("rst_hold", 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge frame_clk);
    Reset = 1'b0;
    @(posedge frame_clk);
    #1;

    // Asynchronous reset mid-cooldown.
    shot_hit = 1'b1;
    repeat (2) @(posedge frame_clk);
    #1;
    check_all("pre_rst_cool", 4'd3, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    #1;
    check_all("rst_cool", 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hit held high across reset release is not a fresh edge for one frame
    // only if the edge register saw it; after reset the register is 0, so
    // a still-high input is taken as a new edge.
    @(negedge frame_clk);
    Reset = 1'b0;
    @(posedge frame_clk);
    #1;
    check_all("held_after_rst", 4'd3, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    shot_hit = 1'b0;

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule
`default_nettype wire
